// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction fetch with in-order prefetch queue and redirect flush
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [31:0] i_addr_out,
    output logic        i_req_out,
    input  logic        i_gnt_in,
    input  logic        i_rvalid_in,
    input  logic [31:0] i_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [6:0]  opcode_out,
    output logic [2:0]  funct3_out,
    output logic        funct7_5_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 2;
    // Back-to-back redirects can stack discards beyond DEPTH, so drop gets extra headroom.
    localparam int DW = 8;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [AW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [AW-1:0] a_head_q, a_head_d, a_tail_q, a_tail_d;

    logic [31:0] q_pc_q   [DEPTH];
    logic [31:0] q_word_q [DEPTH];
    logic [31:0] a_pc_q   [DEPTH];

    logic          pop;
    logic          gnt_fire;
    logic          live_rsp;
    logic          push;
    logic [CW-1:0] inflight;

    assign instr_valid_out = (count_q != '0);
    assign pop             = instr_valid_out & instr_ready_in;
    assign inflight        = count_q + outst_q - CW'(pop);
    assign i_req_out       = !rst_in && !redirect_in && (inflight < CW'(DEPTH));
    assign i_addr_out      = fetch_pc_q;
    assign gnt_fire        = i_req_out & i_gnt_in;
    assign live_rsp        = i_rvalid_in && (drop_q == '0);
    assign push            = live_rsp && !redirect_in;

    assign instr_out    = q_word_q[q_head_q];
    assign pc_out       = q_pc_q[q_head_q];
    assign opcode_out   = instr_out[6:0];
    assign funct3_out   = instr_out[14:12];
    assign funct7_5_out = instr_out[30];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        q_head_d   = q_head_q;
        q_tail_d   = q_tail_q;
        a_head_d   = a_head_q;
        a_tail_d   = a_tail_q;
        if (redirect_in) begin
            // Every request still on the bus becomes a discard; the PC tags for them are no longer needed.
            fetch_pc_d = redirect_pc_in & 32'hFFFF_FFFC;
            count_d    = '0;
            q_head_d   = q_tail_q;
            outst_d    = '0;
            a_head_d   = a_tail_q;
            drop_d     = drop_q + DW'(outst_q) + DW'(gnt_fire) - DW'(i_rvalid_in);
        end else begin
            if (gnt_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                a_tail_d   = a_tail_q + AW'(1);
            end
            if (live_rsp) begin
                a_head_d = a_head_q + AW'(1);
            end
            if (push) begin
                q_tail_d = q_tail_q + AW'(1);
            end
            if (pop) begin
                q_head_d = q_head_q + AW'(1);
            end
            outst_d = outst_q + CW'(gnt_fire) - CW'(live_rsp);
            drop_d  = drop_q - DW'(i_rvalid_in && (drop_q != '0));
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            a_head_q   <= '0;
            a_tail_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_word_q[i] <= '0;
                a_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            a_head_q   <= a_head_d;
            a_tail_q   <= a_tail_d;
            if (gnt_fire) begin
                a_pc_q[a_tail_q] <= fetch_pc_q;
            end
            if (push) begin
                q_pc_q[q_tail_q]   <= a_pc_q[a_head_q];
                q_word_q[q_tail_q] <= i_rdata_in;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] i_addr_out;
    logic        i_req_out;
    logic        i_gnt_in = 1'b0;
    logic        i_rvalid_in = 1'b0;
    logic [31:0] i_rdata_in = '0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        instr_valid_out;
    logic        instr_ready_in = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic        funct7_5_out;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .i_addr_out      (i_addr_out),
        .i_req_out       (i_req_out),
        .i_gnt_in        (i_gnt_in),
        .i_rvalid_in     (i_rvalid_in),
        .i_rdata_in      (i_rdata_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .instr_valid_out (instr_valid_out),
        .instr_ready_in  (instr_ready_in),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .opcode_out      (opcode_out),
        .funct3_out      (funct3_out),
        .funct7_5_out    (funct7_5_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream: sequential PCs from the last reset/redirect target, word = mem_word(pc).
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] mon_pc;
    logic [31:0] mon_w;
    int          pops = 0;

    always @(negedge clk) begin
        if (instr_valid_out && instr_ready_in) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            mon_pc = exp_q.pop_front();
            mon_w  = mem_word(mon_pc);
            pops++;
            check("pop_pc", pc_out, mon_pc);
            check("pop_instr", instr_out, mon_w);
            check("pop_opcode", {25'd0, opcode_out}, {25'd0, mon_w[6:0]});
            check("pop_funct3", {29'd0, funct3_out}, {29'd0, mon_w[14:12]});
            check("pop_funct7_5", {31'd0, funct7_5_out}, {31'd0, mon_w[30]});
        end
        if (rst_in) begin
            exp_q.delete();
            model_pc = RESET_PC;
        end else if (redirect_in) begin
            exp_q.delete();
            model_pc = redirect_pc_in & 32'hFFFF_FFFC;
        end
    end

    // Bus model: in-order responses, each due a random delay after its grant.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t pend[$];

    int          cyc = 0;
    int          grants = 0;
    int          gnt_pct = 100;
    int          min_dly = 0;
    int          max_dly = 0;
    int          rdy_pct = 100;
    int          redir_pct = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = '0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic step();
        rsp_t r;
        @(negedge clk);
        s_req   = i_req_out;
        s_addr  = i_addr_out;
        s_valid = instr_valid_out;
        s_pc    = pc_out;
        s_instr = instr_out;
        if (rst_in) begin
            pend.delete();
        end else begin
            if (i_rvalid_in && pend.size() > 0) pend.delete(0);
            if (i_req_out && i_gnt_in) begin
                r.addr = i_addr_out;
                r.due  = cyc + 1 + int'($urandom_range(min_dly, max_dly));
                pend.push_back(r);
                grants++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        i_gnt_in = ($urandom_range(0, 99) < gnt_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            i_rvalid_in = 1'b1;
            i_rdata_in  = mem_word(pend[0].addr);
        end else begin
            i_rvalid_in = 1'b0;
            i_rdata_in  = $urandom;
        end
        instr_ready_in = ($urandom_range(0, 99) < rdy_pct);
        if (force_redir) begin
            redirect_in    = 1'b1;
            redirect_pc_in = force_pc;
            force_redir    = 1'b0;
        end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
            redirect_in    = 1'b1;
            redirect_pc_in = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        end else begin
            redirect_in = 1'b0;
        end
    endtask

    task automatic do_reset();
        redir_pct = 0;
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        grants = 0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!s_valid && n < 40) begin
            step();
            n++;
        end
        if (!s_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: no valid within 40 cycles", name);
        end
    endtask

    initial begin
        int vcnt;
        int p0;
        int guard;

        // 1: reset state then zero-wait fill and streaming
        gnt_pct = 100; min_dly = 0; max_dly = 0; rdy_pct = 100;
        do_reset();
        check("rst_req", {31'd0, s_req}, 32'd0);
        check("rst_valid", {31'd0, s_valid}, 32'd0);
        check("rst_pc_out", s_pc, 32'd0);
        check("rst_instr_out", s_instr, 32'd0);
        step();
        check("t1_req0", {31'd0, s_req}, 32'd1);
        check("t1_addr0", s_addr, RESET_PC);
        check("t1_valid0", {31'd0, s_valid}, 32'd0);
        step();
        check("t1_addr1", s_addr, RESET_PC + 32'd4);
        check("t1_valid1", {31'd0, s_valid}, 32'd0);
        step();
        check("t1_addr2", s_addr, RESET_PC + 32'd8);
        check("t1_valid2", {31'd0, s_valid}, 32'd1);
        check("t1_pc2", s_pc, RESET_PC);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid) vcnt++;
        end
        check("t1_throughput", 32'(vcnt), 32'd10);

        // 2: decode stalled, queue fills to DEPTH then resumes
        rdy_pct = 0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("t2_grants", 32'(grants), 32'(DEPTH));
        check("t2_req_off", {31'd0, s_req}, 32'd0);
        p0 = pops;
        rdy_pct = 100;
        for (int i = 0; i < 20; i++) step();
        check("t2_resume", 32'(pops - p0 >= 15), 32'd1);

        // 3: redirect with two responses still outstanding
        rdy_pct = 0; min_dly = 4; max_dly = 4;
        do_reset();
        step();
        force_redir = 1'b1; force_pc = 32'h0000_0100; rdy_pct = 100;
        step();
        step();
        check("t3_outstanding", 32'(pend.size()), 32'd2);
        check("t3_req_in_redirect", {31'd0, s_req}, 32'd0);
        step();
        check("t3_new_addr", s_addr, 32'h0000_0100);
        wait_valid("t3_wait");
        check("t3_first_pc", s_pc, 32'h0000_0100);
        check("t3_first_instr", s_instr, mem_word(32'h0000_0100));
        for (int i = 0; i < 20; i++) step();

        // 4: redirect in a cycle with gnt and rvalid, misaligned target
        min_dly = 0; max_dly = 0; rdy_pct = 100;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        force_redir = 1'b1; force_pc = 32'h0000_0203;
        step();
        step();
        check("t4_rvalid_in_redirect", {31'd0, i_rvalid_in}, 32'd0);
        check("t4_req_in_redirect", {31'd0, s_req}, 32'd0);
        step();
        check("t4_aligned_addr", s_addr, 32'h0000_0200);
        check("t4_req_after", {31'd0, s_req}, 32'd1);
        wait_valid("t4_wait");
        check("t4_first_pc", s_pc, 32'h0000_0200);
        for (int i = 0; i < 20; i++) step();

        // 6: reset while full
        rdy_pct = 0; min_dly = 1; max_dly = 3;
        do_reset();
        for (int i = 0; i < 12; i++) step();
        check("t6_full_req", {31'd0, s_req}, 32'd0);
        check("t6_full_valid", {31'd0, s_valid}, 32'd1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        step();
        check("t6_valid", {31'd0, s_valid}, 32'd0);
        check("t6_addr", s_addr, RESET_PC);
        check("t6_req", {31'd0, s_req}, 32'd1);
        rdy_pct = 100;
        for (int i = 0; i < 20; i++) step();

        // 5: random bus timing, stalls and redirects against the reference stream
        gnt_pct = 60; min_dly = 0; max_dly = 5; rdy_pct = 70;
        do_reset();
        redir_pct = 2;
        p0 = pops;
        guard = 0;
        while ((pops - p0) < 4000 && guard < 40000) begin
            step();
            guard++;
        end
        check("t5_progress", 32'(pops - p0 >= 4000), 32'd1);
        redir_pct = 0;
        for (int i = 0; i < 10; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
